seg7_scan_driver: RTL and testbench

//  Consumes the CPU top's 16-bit output port (portOut) and drives a 4-digit, common-anode,

---
 rtl/seg7_scan_driver_pkg.sv | 15 +
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg7_scan_driver.sv | 98 +++++++++
 tb/tb_seg7_scan_driver.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: hex segment table, off patterns, digit count.
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low gfedcba patterns, entry 15 first so HEX7_TABLE[n] selects nibble n.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment (gfedcba) decoder.
module seg7_hex_decoder
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode hex display driver with a frame-synchronous shadow register.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [15:0] portIn,
  output logic [7:0]  segOut,
  output logic [3:0]  anOut,
  output logic        frameOut
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          run_q;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          blank;
  logic          suppress;
  logic [3:0]    nibble;
  logic [6:0]    seg_n;

  assign tick   = (cnt_q == CW'(DIV - 1));
  assign blank  = (cnt_q < CW'(BLANK_CYCLES));
  assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every more significant nibble of the shadow are zero.
  assign suppress = (idx_q != 2'd0) && ((shadow_q >> {idx_q, 2'b00}) == 16'h0000);
`else
  assign suppress = 1'b0;
`endif

  seg7_hex_decoder u_hex (
    .nibble_i (nibble),
    .seg_n_o  (seg_n)
  );

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    frame_d  = run_q && (idx_q == 2'd0) && (cnt_q == '0);
    // run_q holds the scan at (0,0) for the first edge after reset release.
    if (run_q) begin
      if (tick) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(NUM_DIGITS - 1)) begin
          shadow_d = portIn;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (!blank && !suppress) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = {1'b1, seg_n};
      end
    end
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      run_q    <= 1'b0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      run_q    <= 1'b1;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign anOut    = an_q;
  assign segOut   = seg_q;
  assign frameOut = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (DIV=4, BLANK_CYCLES=1) against a frame-level display model.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] port_in;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_out;

  int          n_checks;
  int          n_pass;
  int          edges;
  int          last_frame;
  logic [15:0] shadow_m;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clkIn    (clk),
    .resetIn  (rst_n),
    .portIn   (port_in),
    .segOut   (seg_out),
    .anOut    (an_out),
    .frameOut (frame_out)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, edges);
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"}, {12'h0, an_out}, 16'h000F);
    check({tag, "_seg"}, {8'h0, seg_out}, 16'h00FF);
    check({tag, "_frame"}, {15'h0, frame_out}, 16'h0000);
  endtask

  // One clock: advance, then compare outputs with the model on the falling edge.
  task automatic step();
    int s, p, idx, cnt;
    logic [3:0] digit;
    logic       lit;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    @(posedge clk);
    edges++;
    @(negedge clk);
    if (edges < 2) begin
      check_off("startup");
    end else begin
      s   = edges - 2;
      p   = s % FRAME;
      idx = p / DIV;
      cnt = p % DIV;
      digit = 4'((shadow_m >> (4 * idx)) & 16'hF);
      lit = (cnt >= BLANK);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx > 0 && (shadow_m >> (4 * idx)) == 16'h0) lit = 1'b0;
`endif
      exp_an  = lit ? (4'hF & ~(4'b0001 << idx)) : 4'hF;
      exp_seg = lit ? {1'b1, hex_tab[digit]} : 8'hFF;
      check("anode", {12'h0, an_out}, {12'h0, exp_an});
      check("segment", {8'h0, seg_out}, {8'h0, exp_seg});
      check("frame", {15'h0, frame_out}, {15'h0, (p == 0)});
      check("anode_max_one", 16'($countones(~an_out) <= 1), 16'd1);
      if (p == FRAME - 1) shadow_m = port_in;
    end
    if (frame_out) begin
      if (last_frame > 0) check("frame_period", 16'(edges - last_frame), 16'(FRAME));
      last_frame = edges;
    end
  endtask

  task automatic do_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1 check_off("reset_async");
    repeat (cycles) begin
      @(negedge clk);
      check_off("reset_hold");
    end
    rst_n      = 1'b1;
    edges      = 0;
    last_frame = 0;
    shadow_m   = 16'h0000;
  endtask

  task automatic run_to_step(input int target);
    int guard;
    guard = 0;
    while ((edges - 2) != target && guard < 1000) begin
      step();
      guard++;
    end
    if (guard >= 1000) check("run_timeout", 16'd1, 16'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    edges      = 0;
    last_frame = 0;
    shadow_m   = 16'h0000;
    rst_n      = 1'b1;
    port_in    = 16'h1234;

    repeat (2) @(negedge clk);
    do_reset(3);

    // First frame still shows the reset shadow; second frame shows 1234.
    run_to_step(FRAME + 1);
    check("f2_d0_an", {12'h0, an_out}, 16'h000E);
    check("f2_d0_seg", {8'h0, seg_out}, 16'h0099);
    run_to_step(FRAME + 3 * DIV + 1);
    check("f2_d3_an", {12'h0, an_out}, 16'h0007);
    check("f2_d3_seg", {8'h0, seg_out}, 16'h00F9);

    // Change during digit 1 of frame 3; the value appears in frame 4.
    run_to_step(2 * FRAME + DIV + 1);
    port_in = 16'hABCD;
    run_to_step(3 * FRAME + 1);
    check("abcd_d0_seg", {8'h0, seg_out}, 16'h00A1);
    run_to_step(5 * FRAME);

    foreach (port_in[i]) begin end
    port_in = 16'h0005;
    repeat (2 * FRAME) step();
    port_in = 16'h0000;
    repeat (2 * FRAME) step();
    port_in = 16'h1000;
    repeat (2 * FRAME) step();

    for (int k = 0; k < 8 * FRAME; k++) begin
      step();
      if ($urandom_range(0, 5) == 0) port_in = 16'($urandom);
    end

    // Reset at idx=2, cnt=2 (state after the edge) with a nonzero shadow.
    port_in = 16'h8E3F;
    repeat (2 * FRAME) step();
    while (((edges - 1) % FRAME) != 2 * DIV + 2) step();
    do_reset(2);
    port_in = 16'h4C7B;
    repeat (3 * FRAME) step();

    for (int k = 0; k < 4 * FRAME; k++) begin
      step();
      if ($urandom_range(0, 3) == 0) port_in = 16'($urandom_range(0, 15) << (4 * $urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule
